icache_assoc: RTL and testbench
===============================

Name: icache_assoc

Overview:
Parametrised set-associative instruction cache between the instruction fetch unit and the memory controller. Replaces the single-word direct-mapped I-cache with multi-word lines, 1- or 2-way associativity and LRU replacement. Line refill is a word-by-word burst with critical-word forwarding. A flush port invalidates the whole cache for fence.i.

Parameters:
WAYS, 2, associativity; legal values 1 or 2
SETS, 128, number of sets; power of 2, at least 2
LINE_WORDS, 4, 32-bit words per line; power of 2, at least 2
- Derived: OFF_W = log2(LINE_WORDS), IDX_W = log2(SETS).
- Address split: word offset pc[OFF_W+1:2], index pc[IDX_W+OFF_W+1:OFF_W+2], tag = remaining upper bits of pc.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
rdy  in  1  global ready; when low, all state is frozen
fetch_enable  in  1  fetch unit is requesting pc
pc  in  32  fetch address, word aligned
hit  out  1  combinational; hit_data is valid for pc this cycle
hit_data  out  32  instruction for pc
flush  in  1  invalidate all lines
mem_enable  out  1  refill request active
mem_addr  out  32  word address currently requested
mem_data  in  32  returned word
mem_valid  in  1  one-cycle pulse: mem_data is the word at mem_addr

Behaviour:
- Reset, synchronous:
  - state=IDLE, mem_enable=0, mem_addr=0, word counter=0, flush_pending=0.
  - All valid bits 0, all LRU bits 0.
  - Data and tag arrays need not be cleared.
- Array hit (combinational): fetch_enable && some way w has valid[w][idx] && tag[w][idx]==pc tag; hit_data=data[w][idx][off].
- Forward hit: fetch_enable && state==REFILL && mem_valid && mem_addr==pc; hit_data=mem_data. Forward takes priority over an array hit.
- hit is 0 whenever fetch_enable=0.
- Arrays use asynchronous read, synchronous write.
- IDLE:
  - fetch_enable && !hit && !flush: latch line base {pc[31:OFF_W+2], 0}.
  - Select victim: lowest-numbered invalid way in the set; if all ways are valid, the way named by LRU. WAYS=1 always selects way 0.
  - Next cycle: mem_enable=1, mem_addr=base, counter=0, state=REFILL. Miss-to-request latency is 1 cycle.
  - Array hit with rdy: lru[idx] <= the way not hit (WAYS=2 only).
- REFILL:
  - mem_enable held high throughout.
  - On each mem_valid (with rdy): write mem_data into data[victim][idx][counter]; counter++; mem_addr += 4 the following cycle.
  - On the mem_valid of word LINE_WORDS-1:
    - tag[victim][idx] <= latched tag.
    - valid[victim][idx] <= !flush_pending && !flush.
    - lru[idx] <= non-victim way.
    - mem_enable <= 0, flush_pending <= 0, state <= IDLE.
  - Refill runs to completion regardless of fetch_enable or pc changes; there is no mid-line cancel.
  - Array hits to other lines are served during REFILL (hit-under-miss). LRU is not updated by hits during REFILL.
  - The line being filled never array-hits before it completes.
- Flush:
  - IDLE: all valid bits cleared next cycle; no refill starts that cycle.
  - REFILL: all valid bits cleared; flush_pending set so the in-flight line finishes invalid.
- rdy=0: no state, array, counter or output register changes; mem_valid is ignored; hit stays combinational.
- Reset mid-refill: the burst is abandoned. mem_enable=0 the next cycle; the memory controller is reset by the same rst.

Decomposition:
- Shared package/include const_def.v: IDLE/REFILL state encodings, and OFF_W/IDX_W/tag-width helper macros or functions.
- One natural sub-module, icache_way: one way's data, tag and valid arrays plus its tag compare. It is instantiated WAYS times.
- The top level holds the FSM, LRU bits, victim select, address counter and forwarding mux.

Test Plan:
All cases use defaults: offset [3:2], index [10:4], tag [31:11].
- Cold miss, pc=0x100:
  - mem_enable rises 1 cycle later; mem_addr runs 0x100, 0x104, 0x108, 0x10C.
  - hit=1 with the returned word on the 0x100 mem_valid cycle.
  - Afterwards pc=0x108 hits in the same cycle with the stored word.
- Forward of a later word: pc held at 0x10C during a refill of 0x100 -> hit=1 exactly on the fourth mem_valid, with hit_data=mem_data.
- Conflict and LRU in set 0x10:
  - Fill 0x100, then 0x900 (fills way 1), then hit 0x100, then miss 0x1100.
  - 0x1100 evicts the 0x900 line; 0x100 still hits and 0x900 misses.
- Flush during refill: flush pulsed after the second word -> burst completes all 4 words; afterwards 0x100 misses and a new refill starts.
- rdy low for 3 cycles mid-burst, with a mem_valid pulse among them -> mem_addr and counter are unchanged; that word is not written; the burst resumes when rdy=1.
- rst during refill -> mem_enable=0 next cycle; the next access to 0x100 misses.

Source files
------------

// File: rtl/icache_assoc_pkg.sv
// Shared definitions for the set-associative instruction cache: FSM states
// and the tag-width helper derived from the set/line geometry.
package icache_assoc_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    // Tag bits left after the byte offset, word offset and set index are removed.
    function automatic int line_tag_w(input int sets, input int line_words);
        return 30 - $clog2(sets) - $clog2(line_words);
    endfunction

endpackage

// File: rtl/icache_assoc_way.sv
// One cache way: data, tag and valid arrays with asynchronous read, synchronous
// write, plus the tag compare for the current fetch address.
module icache_assoc_way #(
    parameter int SETS       = 128,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = 7,
    parameter int OFF_W      = 2,
    parameter int TAG_W      = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFF_W-1:0] rd_off,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             match,
    output logic             valid_at,
    output logic [31:0]      rd_data,
    input  logic             flush_all,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OFF_W-1:0] wr_off,
    input  logic [31:0]      wr_data,
    input  logic             data_we,
    input  logic             tag_we,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             valid_we,
    input  logic             wr_valid
);

    logic [31:0]      data_mem [SETS*LINE_WORDS];
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [SETS-1:0]  valid_reg;

    always_ff @(posedge clk) begin
        if (rdy && data_we)
            data_mem[{wr_idx, wr_off}] <= wr_data;
        if (rdy && tag_we)
            tag_mem[wr_idx] <= wr_tag;
    end

    // A single-line valid write issued alongside a flush always carries 0,
    // so letting it land after the bulk clear is safe.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
        end else if (rdy) begin
            if (flush_all)
                valid_reg <= '0;
            if (valid_we)
                valid_reg[wr_idx] <= wr_valid;
        end
    end

    assign valid_at = valid_reg[rd_idx];
    assign match    = valid_reg[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_data  = data_mem[{rd_idx, rd_off}];

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: refill FSM, LRU, victim selection,
// burst address counter and critical-word forwarding.
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 128,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        fetch_enable,
    input  logic [31:0] pc,
    output logic        hit,
    output logic [31:0] hit_data,
    input  logic        flush,
    output logic        mem_enable,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_valid
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = line_tag_w(SETS, LINE_WORDS);
    localparam int LINE_W = 30 - OFF_W;

    state_t            state_reg;
    logic              mem_enable_reg;
    logic [31:0]       mem_addr_reg;
    logic [OFF_W-1:0]  cnt_reg;
    logic              victim_reg;
    logic              fp_reg;
    logic [SETS-1:0]   lru_reg;
    logic [LINE_W-1:0] line_reg;

    logic [OFF_W-1:0]  pc_off;
    logic [IDX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]  pc_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic [IDX_W-1:0]  wr_idx;

    logic [WAYS-1:0]   match;
    logic [WAYS-1:0]   valid_at;
    logic [31:0]       way_data [WAYS];
    logic [31:0]       array_data;
    logic              hit_way;
    logic              victim_next;
    logic              forward_hit;
    logic              array_hit;
    logic              start_miss;
    logic              refill_beat;
    logic              last_word;

    assign pc_off   = pc[OFF_W+1:2];
    assign pc_idx   = pc[IDX_W+OFF_W+1:OFF_W+2];
    assign pc_tag   = pc[31:IDX_W+OFF_W+2];
    assign fill_idx = line_reg[IDX_W-1:0];
    assign fill_tag = line_reg[LINE_W-1:IDX_W];
    assign wr_idx   = (state_reg == IDLE) ? pc_idx : fill_idx;

    assign last_word   = &cnt_reg;
    assign refill_beat = (state_reg == REFILL) && mem_valid;
    assign forward_hit = fetch_enable && rdy && refill_beat && (mem_addr_reg == pc);
    assign array_hit   = fetch_enable && (|match);
    assign hit         = forward_hit || array_hit;
    assign hit_data    = forward_hit ? mem_data : array_data;
    assign start_miss  = rdy && (state_reg == IDLE) && fetch_enable && !array_hit && !flush;

    generate
        if (WAYS == 2) begin : g_two_way
            assign hit_way     = match[1];
            assign array_data  = match[1] ? way_data[1] : way_data[0];
            assign victim_next = !valid_at[0] ? 1'b0 :
                                 !valid_at[1] ? 1'b1 : lru_reg[pc_idx];
        end else begin : g_one_way
            assign hit_way     = 1'b0;
            assign array_data  = way_data[0];
            assign victim_next = 1'b0;
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            localparam bit WAY_ID = (gi == 1);
            logic fill_we;
            assign fill_we = refill_beat && (victim_reg == WAY_ID);

            icache_assoc_way #(
                .SETS(SETS), .LINE_WORDS(LINE_WORDS),
                .IDX_W(IDX_W), .OFF_W(OFF_W), .TAG_W(TAG_W)
            ) u_way (
                .clk      (clk),
                .rst      (rst),
                .rdy      (rdy),
                .rd_idx   (pc_idx),
                .rd_off   (pc_off),
                .rd_tag   (pc_tag),
                .match    (match[gi]),
                .valid_at (valid_at[gi]),
                .rd_data  (way_data[gi]),
                .flush_all(flush),
                .wr_idx   (wr_idx),
                .wr_off   (cnt_reg),
                .wr_data  (mem_data),
                .data_we  (fill_we),
                .tag_we   (fill_we && last_word),
                .wr_tag   (fill_tag),
                // The victim line is dropped at miss time so stale data never
                // hits while it is partially overwritten.
                .valid_we ((fill_we && last_word) || (start_miss && (victim_next == WAY_ID))),
                .wr_valid (!start_miss && !fp_reg && !flush)
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            mem_enable_reg <= 1'b0;
            mem_addr_reg   <= '0;
            cnt_reg        <= '0;
            victim_reg     <= 1'b0;
            fp_reg         <= 1'b0;
            lru_reg        <= '0;
            line_reg       <= '0;
        end else if (rdy) begin
            case (state_reg)
                IDLE: begin
                    if (WAYS == 2 && array_hit)
                        lru_reg[pc_idx] <= ~hit_way;
                    if (start_miss) begin
                        line_reg       <= pc[31:OFF_W+2];
                        victim_reg     <= victim_next;
                        mem_enable_reg <= 1'b1;
                        mem_addr_reg   <= {pc[31:OFF_W+2], {(OFF_W+2){1'b0}}};
                        cnt_reg        <= '0;
                        state_reg      <= REFILL;
                    end
                end
                REFILL: begin
                    if (flush)
                        fp_reg <= 1'b1;
                    if (mem_valid) begin
                        cnt_reg      <= cnt_reg + 1'b1;
                        mem_addr_reg <= mem_addr_reg + 32'd4;
                        if (last_word) begin
                            lru_reg[fill_idx] <= ~victim_reg;
                            mem_enable_reg    <= 1'b0;
                            fp_reg            <= 1'b0;
                            state_reg         <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem_enable = mem_enable_reg;
    assign mem_addr   = mem_addr_reg;

endmodule

// File: tb/tb_icache_assoc.sv
// Randomised and directed bench for icache_assoc (default geometry), checked
// cycle by cycle against a line-level behavioural model of the cache.
module tb_icache_assoc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        fetch_enable = 1'b0;
    logic [31:0] pc = '0;
    logic        hit;
    logic [31:0] hit_data;
    logic        flush = 1'b0;
    logic        mem_enable;
    logic [31:0] mem_addr;
    logic [31:0] mem_data = '0;
    logic        mem_valid = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    icache_assoc #(.WAYS(2), .SETS(128), .LINE_WORDS(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .fetch_enable(fetch_enable), .pc(pc),
        .hit(hit), .hit_data(hit_data), .flush(flush), .mem_enable(mem_enable),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_valid(mem_valid)
    );

    always #5 clk = ~clk;

    // Reference model: whole lines per (way, set), a refill in flight, LRU per set.
    bit          m_known = 0;
    bit          m_refill = 0;
    bit          m_fp = 0;
    int          m_vic = 0;
    int unsigned m_base = 0;
    int          m_cnt = 0;
    bit          m_valid [2][128];
    int unsigned m_tag   [2][128];
    logic [31:0] m_data  [2][128][4];
    bit          m_lru   [128];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0001;
    endfunction

    task automatic model_reset();
        m_known = 1; m_refill = 0; m_fp = 0; m_cnt = 0;
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 128; s++) m_valid[w][s] = 0;
        for (int s = 0; s < 128; s++) m_lru[s] = 0;
    endtask

    task automatic clear_valid();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 128; s++) m_valid[w][s] = 0;
    endtask

    // One clock cycle: drive at negedge, compare against the model, advance the model.
    task automatic cyc(input logic fe, input logic [31:0] p, input logic fl,
                       input logic r, input logic mv, input logic rs);
        int          set, off, aw, bset;
        int unsigned tg;
        bit          fwd, exp_hit, fp_old;
        logic [31:0] exp_data;
        @(negedge clk);
        fetch_enable = fe; pc = p; flush = fl; rdy = r; rst = rs;
        mem_valid = mv && mem_enable;
        mem_data  = r ? memw(mem_addr) : $urandom;
        #1;
        set = int'((p >> 4) & 32'd127);
        off = int'((p >> 2) & 32'd3);
        tg  = p >> 11;
        aw  = -1;
        for (int w = 0; w < 2; w++)
            if (m_valid[w][set] && m_tag[w][set] == tg) aw = w;
        fwd      = fe && r && m_refill && mem_valid && (p == m_base + 32'(4 * m_cnt));
        exp_hit  = fwd || (fe && aw >= 0);
        exp_data = fwd ? mem_data : ((aw >= 0) ? m_data[aw][set][off] : 32'h0);
        if (m_known) begin
            check("mem_enable", {31'd0, mem_enable}, {31'd0, m_refill});
            if (m_refill) check("mem_addr", mem_addr, m_base + 32'(4 * m_cnt));
            check("hit", {31'd0, hit}, {31'd0, exp_hit});
            if (exp_hit) check("hit_data", hit_data, exp_data);
        end
        if (rs) begin
            model_reset();
        end else if (r && m_known) begin
            if (!m_refill) begin
                if (fe && aw >= 0) m_lru[set] = (aw == 0);
                if (fl) begin
                    clear_valid();
                end else if (fe && aw < 0) begin
                    m_vic = !m_valid[0][set] ? 0 : (!m_valid[1][set] ? 1 : int'(m_lru[set]));
                    m_valid[m_vic][set] = 0;
                    m_base = p & ~32'hF;
                    m_cnt = 0;
                    m_refill = 1;
                end
            end else begin
                fp_old = m_fp;
                if (fl) begin
                    clear_valid();
                    m_fp = 1;
                end
                if (mem_valid) begin
                    bset = int'((m_base >> 4) & 32'd127);
                    m_data[m_vic][bset][m_cnt] = mem_data;
                    if (m_cnt == 3) begin
                        m_tag[m_vic][bset]   = m_base >> 11;
                        m_valid[m_vic][bset] = !fp_old && !fl;
                        m_lru[bset]          = (m_vic == 0);
                        m_refill = 0;
                        m_fp = 0;
                        m_cnt = 0;
                    end else begin
                        m_cnt++;
                    end
                end
            end
        end
    endtask

    // Miss on a, then keep fetching hold_pc while the burst drains at a random pace.
    task automatic fill(input logic [31:0] a, input logic [31:0] hold_pc);
        int n = 0;
        cyc(1, a, 0, 1, 0, 0);
        while (m_refill && n < 60) begin
            cyc(1, hold_pc, 0, 1, ($urandom_range(0, 3) != 0), 0);
            n++;
        end
        if (n >= 60) check("fill_timeout", {31'd0, mem_enable}, 32'd0);
        $display("fill line %h hold %h: %0d cycles", a, hold_pc, n);
    endtask

    task automatic drain();
        int n = 0;
        while (m_refill && n < 60) begin
            cyc(0, 32'h0, 0, 1, 1, 0);
            n++;
        end
        if (n >= 60) check("drain_timeout", {31'd0, mem_enable}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 32'h100, 0, 1, 0, 0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_mem_enable", {31'd0, mem_enable}, 32'd0);

        // Cold miss with critical-word forward, then same-cycle hit on a stored word.
        fill(32'h100, 32'h100);
        cyc(1, 32'h108, 0, 1, 0, 0);
        check("cold_hit_108", {31'd0, hit}, 32'd1);
        check("cold_data_108", hit_data, memw(32'h108));

        // Later-word forward, conflict fill and LRU eviction in set 0x10.
        fill(32'h300, 32'h30C);
        fill(32'h900, 32'h900);
        cyc(1, 32'h100, 0, 1, 0, 0);
        fill(32'h1100, 32'h1100);
        cyc(1, 32'h100, 0, 1, 0, 0);
        check("lru_keep_100", {31'd0, hit}, 32'd1);
        cyc(1, 32'h900, 0, 1, 0, 0);
        check("lru_evict_900", {31'd0, hit}, 32'd0);
        drain();

        // Flush mid-burst: line completes but stays invalid.
        cyc(0, 0, 1, 1, 0, 0);
        cyc(1, 32'h100, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 0, 0);
        drain();
        cyc(1, 32'h100, 0, 1, 0, 0);
        check("flush_miss_100", {31'd0, hit}, 32'd0);
        drain();

        // rdy low for three cycles with an ignored mem_valid among them.
        cyc(1, 32'h500, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("stall_mem_addr", mem_addr, 32'h504);
        drain();
        for (int i = 0; i < 4; i++) begin
            a = 32'h500 + 32'(4 * i);
            cyc(1, a, 0, 1, 0, 0);
            check("stall_data", hit_data, memw(a));
        end

        // Reset mid-refill abandons the burst and clears all lines.
        cyc(1, 32'h600, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 1, 0, 0);
        check("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
        cyc(1, 32'h100, 0, 1, 0, 0);
        check("rst_miss_100", {31'd0, hit}, 32'd0);
        drain();

        // Random traffic over a few conflicting lines.
        for (int i = 0; i < 3000; i++) begin
            a = (32'($urandom_range(0, 3)) << 11) |
                (32'($urandom_range(0, 2) == 2 ? 16 : $urandom_range(0, 1)) << 4) |
                (32'($urandom_range(0, 3)) << 2);
            cyc($urandom_range(0, 3) != 0, a, $urandom_range(0, 60) == 0,
                $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 799) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
